mem_arbiter: RTL

- Two-master bus arbiter between the 6502 core and a DMA-style requester (video fetch, block copy) that share the single system bus: RAM, GPIO, ACIA and ROM decode.
- Sits between the CPU and the address decode / data mux. It owns the RDY input of the CPU.
- The DMA requester has priority with a bounded burst length, so the CPU is never starved.
- Stalled CPU cycles are counted for software profiling.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master bus arbiter sharing the system bus between the 6502
// core and a DMA-style requester (video fetch, block copy).
//
// The DMA requester wins arbitration, but only for up to DMA_BURST consecutive
// slots. After that, the CPU is forced one slot so that it is never starved.
// The arbiter drives the CPU RDY line and holds the CPU read data steady for
// the whole of a stall. It also counts stalled CPU cycles in a saturating
// counter for software profiling.
//
// Ports:
//   clk        in   system clock, single domain
//   reset      in   synchronous active-low reset (low = reset)
//   cpu_ab     in   CPU address
//   cpu_we     in   CPU write enable
//   cpu_do     in   CPU write data
//   cpu_di     out  read data presented to the CPU (stable while stalled)
//   cpu_rdy    out  CPU RDY, low stalls the CPU
//   dma_req    in   DMA request, held with addr/we/wdata until granted
//   dma_addr   in   DMA address
//   dma_we     in   DMA write enable
//   dma_wdata  in   DMA write data
//   dma_gnt    out  DMA access performed this cycle
//   dma_rvalid out  DMA read data valid (cycle after a granted DMA read)
//   dma_rdata  out  DMA read data
//   mem_ab     out  address to decode
//   mem_we     out  write enable to decode
//   mem_do     out  write data to decode
//   mem_di     in   muxed read data, valid one cycle after its address
//   stall_cnt  out  saturating count of cycles with cpu_rdy low
module mem_arbiter #(
  parameter int DMA_BURST = 4,
  parameter int STALL_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        cpu_ab,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_do,
  output logic [7:0]         cpu_di,
  output logic               cpu_rdy,
  input  logic               dma_req,
  input  logic [15:0]        dma_addr,
  input  logic               dma_we,
  input  logic [7:0]         dma_wdata,
  output logic               dma_gnt,
  output logic               dma_rvalid,
  output logic [7:0]         dma_rdata,
  output logic [15:0]        mem_ab,
  output logic               mem_we,
  output logic [7:0]         mem_do,
  input  logic [7:0]         mem_di,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [3:0]         BURST_MAX_C = 4'(DMA_BURST);
  localparam logic [STALL_W-1:0] STALL_SAT_C = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE_C = STALL_W'(1);

  logic [3:0]         burst_cnt_r;
  logic               last_cpu_r;
  logic               last_dma_rd_r;
  logic [7:0]         hold_di_r;
  logic [STALL_W-1:0] stall_cnt_r;
  logic               owner_dma_s;

  // Slot owner: DMA wins while its burst budget lasts; reset forces the CPU.
  always_comb begin
    owner_dma_s = reset & dma_req & (burst_cnt_r < BURST_MAX_C);
  end

  // Bus steering and handshake outputs follow the current slot owner.
  // A CPU write presented during a DMA slot is simply not issued. The CPU is
  // stalled and repeats it once RDY returns.
  always_comb begin
    cpu_rdy = 1'b1;
    dma_gnt = 1'b0;
    mem_ab  = cpu_ab;
    mem_we  = cpu_we;
    mem_do  = cpu_do;
    if (owner_dma_s) begin
      cpu_rdy = 1'b0;
      dma_gnt = 1'b1;
      mem_ab  = dma_addr;
      mem_we  = dma_we;
      mem_do  = dma_wdata;
    end else begin
      cpu_rdy = 1'b1;
      dma_gnt = 1'b0;
      mem_ab  = cpu_ab;
      mem_we  = cpu_we;
      mem_do  = cpu_do;
    end
  end

  // Read-data return paths. The CPU sees live bus data only right after one
  // of its own slots. Otherwise it sees the byte held from that slot.
  always_comb begin
    dma_rdata  = mem_di;
    dma_rvalid = last_dma_rd_r;
    stall_cnt  = stall_cnt_r;
    if (last_cpu_r) begin
      cpu_di = mem_di;
    end else begin
      cpu_di = hold_di_r;
    end
  end

  // Arbitration state, read-return tracking, CPU data hold and stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt_r   <= 4'd0;
      last_cpu_r    <= 1'b1;
      last_dma_rd_r <= 1'b0;
      hold_di_r     <= 8'h00;
      stall_cnt_r   <= {STALL_W{1'b0}};
    end else begin
      // A budget of 1..15 never lets the increment overflow 4 bits.
      if (owner_dma_s) begin
        burst_cnt_r <= burst_cnt_r + 4'd1;
      end else begin
        burst_cnt_r <= 4'd0;
      end
      last_cpu_r    <= ~owner_dma_s;
      last_dma_rd_r <= owner_dma_s & ~dma_we;
      if (last_cpu_r) begin
        hold_di_r <= mem_di;
      end else begin
        hold_di_r <= hold_di_r;
      end
      if (owner_dma_s && (stall_cnt_r != STALL_SAT_C)) begin
        stall_cnt_r <= stall_cnt_r + STALL_ONE_C;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule
